// File: rtl/migcorre_pwm_dc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | migcorre_pwm_dc_if : 8-bit io_in/io_out tile bundle for the PWM block    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface migcorre_pwm_dc_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave (input io_in, output io_out);
endinterface
`default_nettype wire

// File: rtl/migcorre_pwm_dc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | migcorre_pwm_dc : single-channel PWM with saturating push-button duty    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module migcorre_pwm_dc #(
  parameter int PERIOD     = 10,
  parameter int DUTY_RESET = 5,
  parameter int STEP       = 1
) (
  migcorre_pwm_dc_if.slave bus
);
  localparam int              DW           = $clog2(PERIOD + 1);
  localparam logic [DW-1:0]   C_PERIOD     = DW'(PERIOD);
  localparam logic [DW-1:0]   C_LAST       = DW'(PERIOD - 1);
  localparam logic [DW-1:0]   C_DUTY_RESET = DW'(DUTY_RESET);
  localparam logic [DW:0]     C_STEP       = (DW + 1)'(STEP);

  logic w_clk;
  logic w_rst;
  logic w_unused_hi;
  assign w_clk       = bus.io_in[0];
  assign w_rst       = bus.io_in[1];
  assign w_unused_hi = ^bus.io_in[7:4];

  // bit 0 = increase, bit 1 = decrease
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_dly;
  logic [1:0] w_pulse;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_dly   <= 2'b00;
    end else begin
      r_sync1 <= {bus.io_in[3], bus.io_in[2]};
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign w_pulse = r_sync2 & ~r_dly;

  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_duty_pending;
  logic [DW-1:0] r_duty_active;
  logic          r_pwm;
  logic [DW:0]   w_inc_sum;
  logic [DW:0]   w_dec_diff;
  logic [DW-1:0] w_duty_next;

  // One extra bit keeps the saturation compares free of wrap-around.
  assign w_inc_sum  = {1'b0, r_duty_pending} + C_STEP;
  assign w_dec_diff = {1'b0, r_duty_pending} - C_STEP;

  always_comb begin
    w_duty_next = r_duty_pending;
    if (w_pulse[0] && !w_pulse[1]) begin
      w_duty_next = (w_inc_sum > {1'b0, C_PERIOD}) ? C_PERIOD : w_inc_sum[DW-1:0];
    end else if (w_pulse[1] && !w_pulse[0]) begin
      w_duty_next = ({1'b0, r_duty_pending} < C_STEP) ? '0 : w_dec_diff[DW-1:0];
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_cnt          <= '0;
      r_duty_pending <= C_DUTY_RESET;
      r_duty_active  <= C_DUTY_RESET;
      r_pwm          <= 1'b0;
    end else begin
      r_cnt          <= (r_cnt == C_LAST) ? '0 : r_cnt + DW'(1);
      r_duty_pending <= w_duty_next;
      // Duty only changes at the wrap so no period mixes two duty values.
      if (r_cnt == C_LAST) begin
        r_duty_active <= r_duty_pending;
      end
      r_pwm          <= (r_cnt < r_duty_active);
    end
  end

  assign bus.io_out = {6'b000000, ~r_pwm, r_pwm};
endmodule
`default_nettype wire

// File: tb/tb_migcorre_pwm_dc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_migcorre_pwm_dc : scoreboard bench with behavioural duty/PWM model    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_migcorre_pwm_dc;
  localparam int PERIOD     = 10;
  localparam int DUTY_RESET = 5;
  localparam int STEP       = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [3:0] hi  = 4'h0;

  migcorre_pwm_dc_if pif ();
  assign pif.io_in = {hi, dec, inc, rst, clk};

  migcorre_pwm_dc #(
    .PERIOD    (PERIOD),
    .DUTY_RESET(DUTY_RESET),
    .STEP      (STEP)
  ) dut (
    .bus(pif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc    = 0;
  bit exp_q[$];

  // Reference model: edges since reset, duty snapshot per period, and
  // button steps scheduled two edges after the edge that first sees a press.
  int unsigned edge_no = 0;
  int          since_rst = 0;
  int          pend = DUTY_RESET;
  int          cur  = DUTY_RESET;
  bit          prev_inc = 1'b0;
  bit          prev_dec = 1'b0;
  int unsigned inc_due[$];
  int unsigned dec_due[$];

  task automatic model_edge(input bit r, input bit a, input bit b);
    bit e;
    bit inc_now;
    bit dec_now;
    int phase;
    if (r) begin
      since_rst = 0;
      pend = DUTY_RESET;
      cur  = DUTY_RESET;
      prev_inc = 1'b0;
      prev_dec = 1'b0;
      inc_due.delete();
      dec_due.delete();
      exp_q.push_back(1'b0);
    end else begin
      phase = since_rst % PERIOD;
      e = (phase < cur);
      if (phase == PERIOD - 1) cur = pend;
      inc_now = 1'b0;
      dec_now = 1'b0;
      if (inc_due.size() > 0 && inc_due[0] == edge_no) begin
        inc_now = 1'b1;
        void'(inc_due.pop_front());
      end
      if (dec_due.size() > 0 && dec_due[0] == edge_no) begin
        dec_now = 1'b1;
        void'(dec_due.pop_front());
      end
      if (inc_now && !dec_now) pend = (pend + STEP > PERIOD) ? PERIOD : pend + STEP;
      else if (dec_now && !inc_now) pend = (pend < STEP) ? 0 : pend - STEP;
      if (a && !prev_inc) inc_due.push_back(edge_no + 2);
      if (b && !prev_dec) dec_due.push_back(edge_no + 2);
      prev_inc = a;
      prev_dec = b;
      since_rst++;
      exp_q.push_back(e);
    end
    edge_no++;
  endtask

  task automatic step(input bit r, input bit a, input bit b);
    @(negedge clk);
    rst = r;
    inc = a;
    dec = b;
    hi  = 4'($urandom);
    @(posedge clk);
    model_edge(r, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic press(input bit a, input bit b, input int hold);
    for (int i = 0; i < hold; i++) step(1'b0, a, b);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a new output every cycle; checked mid-cycle.
  always @(negedge clk) begin
    bit e;
    logic [7:0] want;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      want = {6'b000000, ~e, e};
      n_checks++;
      if (pif.io_out !== want) begin
        n_errors++;
        $display("FAIL io_out cycle=%0d got=%b expected=%b", n_cyc, pif.io_out, want);
      end
      n_cyc++;
    end
  end

  initial begin
    bit ri;
    bit rd;
    do_reset(3);
    idle(25);

    // single short press, then a long hold that must count once
    press(1'b1, 1'b0, 4);
    idle(25);
    press(1'b1, 1'b0, 25);
    idle(20);

    // saturation high, with an extra press beyond PERIOD
    do_reset(2);
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 2);
    idle(30);

    // saturation low, no underflow wrap
    do_reset(2);
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 2);
    idle(30);

    // simultaneous increase and decrease cancel
    do_reset(2);
    press(1'b1, 1'b1, 3);
    idle(25);

    // press mid-period, then reset mid-period
    do_reset(2);
    idle(13);
    press(1'b1, 1'b0, 2);
    idle(17);
    do_reset(2);
    idle(15);

    // button held through reset release gives one step afterwards
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    idle(20);

    // randomized traffic with occasional resets
    ri = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) ri = ~ri;
      if ($urandom_range(3) == 0) rd = ~rd;
      step(($urandom_range(149) == 0), ri, rd);
    end
    idle(12);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
